// File: rtl/fifo_camera_data_pkg.sv
// fifo_camera_data_pkg: width, depth and threshold defaults for the camera data FIFO
package fifo_camera_data_pkg;
    localparam int DEF_WR_DATA_WIDTH    = 8;
    localparam int DEF_WR_DEPTH_WIDTH   = 15;
    localparam int DEF_RD_DATA_WIDTH    = 32;
    localparam int DEF_RD_DEPTH_WIDTH   = 13;
    localparam int DEF_ALMOST_FULL_NUM  = 32000;
    localparam int DEF_ALMOST_EMPTY_NUM = 512;
endpackage

// File: rtl/fifo_camera_data_if.sv
// fifo_camera_data_if: byte write port and word read port of the camera data FIFO
interface fifo_camera_data_if import fifo_camera_data_pkg::*; #(
    parameter int WR_DATA_WIDTH = DEF_WR_DATA_WIDTH,
    parameter int RD_DATA_WIDTH = DEF_RD_DATA_WIDTH
);
    logic [WR_DATA_WIDTH-1:0] wr_data;
    logic                     wr_en;
    logic                     wr_full;
    logic                     almost_full;
    logic [RD_DATA_WIDTH-1:0] rd_data;
    logic                     rd_en;
    logic                     rd_empty;
    logic                     almost_empty;
    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty
    );
    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty
    );
endinterface

// File: rtl/fifo_camera_data_ram.sv
// fifo_camera_data_ram: simple dual-port RAM with byte-lane writes and a registered read
module fifo_camera_data_ram import fifo_camera_data_pkg::*; #(
    parameter int DW = DEF_WR_DATA_WIDTH,
    parameter int RW = DEF_RD_DATA_WIDTH,
    parameter int AW = DEF_RD_DEPTH_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    be,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [RW-1:0] rd_data
);
    logic [RW-1:0] mem [1<<AW];
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[wr_addr][i*DW +: DW] <= wr_data;
    // only the read register is reset; array contents survive rst
    always_ff @(posedge clk or posedge rst)
        if (rst) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/fifo_camera_data.sv
// fifo_camera_data: single-clock FIFO packing four written bytes into each read word
module fifo_camera_data import fifo_camera_data_pkg::*; #(
    parameter int WR_DATA_WIDTH    = DEF_WR_DATA_WIDTH,
    parameter int WR_DEPTH_WIDTH   = DEF_WR_DEPTH_WIDTH,
    parameter int RD_DATA_WIDTH    = DEF_RD_DATA_WIDTH,
    parameter int RD_DEPTH_WIDTH   = DEF_RD_DEPTH_WIDTH,
    parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
    input logic               clk,
    input logic               rst,
    fifo_camera_data_if.slave bus
);
    localparam int CW = WR_DEPTH_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(1) << WR_DEPTH_WIDTH;
    logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
    logic [RD_DEPTH_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]             count, count_nx;
    logic                      wr_ok, rd_ok;
    logic [3:0]                be;
    always_comb begin
        wr_ok    = bus.wr_en && !bus.wr_full;
        rd_ok    = bus.rd_en && !bus.rd_empty;
        be       = wr_ok ? 4'b1 << wr_ptr[1:0] : 4'b0;
        count_nx = count + CW'(wr_ok) - (rd_ok ? CW'(4) : CW'(0));
    end
    // flags come from the next count so they agree with count after every edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.wr_full      <= 1'b0;
            bus.almost_full  <= 1'b0;
            bus.rd_empty     <= 1'b1;
            bus.almost_empty <= 1'b1;
        end else begin
            wr_ptr           <= wr_ptr + WR_DEPTH_WIDTH'(wr_ok);
            rd_ptr           <= rd_ptr + RD_DEPTH_WIDTH'(rd_ok);
            count            <= count_nx;
            bus.wr_full      <= count_nx == FULL;
            bus.almost_full  <= count_nx >= CW'(ALMOST_FULL_NUM);
            bus.rd_empty     <= count_nx < CW'(4);
            bus.almost_empty <= (count_nx >> 2) <= CW'(ALMOST_EMPTY_NUM);
        end
    fifo_camera_data_ram #(.DW(WR_DATA_WIDTH), .RW(RD_DATA_WIDTH), .AW(RD_DEPTH_WIDTH)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .be      (be),
        .wr_addr (wr_ptr[WR_DEPTH_WIDTH-1:2]),
        .wr_data (bus.wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );
endmodule

// File: tb/tb_fifo_camera_data.sv
// tb_fifo_camera_data: random and directed stimulus against a byte-queue model of the FIFO
module tb_fifo_camera_data;
    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    byte unsigned q[$];
    logic [31:0] exp_rd = '0;

    fifo_camera_data_if bus();
    fifo_camera_data dut (.clk(clk), .rst(tb_rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a byte queue; a read removes the four oldest bytes, oldest in the low lane
    always @(posedge clk or posedge tb_rst) begin
        int n;
        if (tb_rst) begin
            q.delete();
            exp_rd = '0;
        end else begin
            n = q.size();
            if (bus.rd_en && n >= 4) begin
                exp_rd = {q[3], q[2], q[1], q[0]};
                repeat (4) void'(q.pop_front());
            end
            if (bus.wr_en && n < 32768) q.push_back(bus.wr_data);
        end
    end

    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("wr_full", bus.wr_full, 32'(n == 32768));
        chk("almost_full", bus.almost_full, 32'(n >= 32000));
        chk("rd_empty", bus.rd_empty, 32'(n < 4));
        chk("almost_empty", bus.almost_empty, 32'((n / 4) <= 512));
        chk("rd_data", bus.rd_data, exp_rd);
    end

    task automatic cyc(input logic we, input logic [7:0] d, input logic re);
        bus.wr_en = we;
        bus.wr_data = d;
        bus.rd_en = re;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tb_rst = 1'b1;
        @(posedge clk);
        #1 tb_rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_empty"}, bus.rd_empty, 1);
        chk({tag, "_almost_empty"}, bus.almost_empty, 1);
        chk({tag, "_wr_full"}, bus.wr_full, 0);
        chk({tag, "_almost_full"}, bus.almost_full, 0);
        chk({tag, "_rd_data"}, bus.rd_data, 0);
    endtask

    initial begin
        int k;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1 tb_rst = 1'b0;
        chk_reset_outputs("reset");

        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("pack_word", bus.rd_data, 32'h04030201);
        chk("pack_empty_after", bus.rd_empty, 1);

        cyc(1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 8'hBB, 1'b1);
        cyc(1'b1, 8'hCC, 1'b1);
        chk("stall_rd_data_held", bus.rd_data, 32'h04030201);
        cyc(1'b1, 8'hDD, 1'b1);
        chk("stall_empty_clear", bus.rd_empty, 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("stall_word", bus.rd_data, 32'hDDCCBBAA);

        for (int i = 0; i < 2000; i++)
            cyc(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 30));

        do_reset();
        for (int i = 0; i < 32768; i++) begin
            cyc(1'b1, 8'(255 - (i % 256)), 1'b0);
            if (i == 31998) chk("af_before_32000", bus.almost_full, 0);
            if (i == 31999) chk("af_at_32000", bus.almost_full, 1);
            if (i == 32766) chk("full_before_32768", bus.wr_full, 0);
            if (i == 32767) chk("full_at_32768", bus.wr_full, 1);
        end
        cyc(1'b1, 8'h55, 1'b0);
        chk("full_after_extra", bus.wr_full, 1);

        for (int j = 0; j <= 8192; j++) begin
            cyc(1'b0, 8'h00, 1'b1);
            if (j == 0) chk("drain_first_word", bus.rd_data, 32'hFCFDFEFF);
            if (j == 7678) chk("ae_at_513_words", bus.almost_empty, 0);
            if (j == 7679) chk("ae_at_512_words", bus.almost_empty, 1);
            if (j == 8191) begin
                chk("drain_last_word", bus.rd_data, 32'h00010203);
                chk("drain_empty", bus.rd_empty, 1);
            end
            if (j == 8192) chk("drain_extra_read_held", bus.rd_data, 32'h00010203);
        end

        do_reset();
        for (int i = 0; i < 400; i++) cyc(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 8'($urandom), 1'b1);
        k = 0;
        while (!bus.rd_empty && k < 200) begin
            cyc(1'b0, 8'h00, 1'b1);
            k++;
        end
        chk("simul_words_left", 32'(k), 32'd70);

        do_reset();
        for (int i = 0; i < 1000; i++) cyc(1'b1, 8'($urandom), 1'b0);
        bus.wr_en = 1'b0;
        #2 tb_rst = 1'b1;
        #1 chk_reset_outputs("midreset");
        @(posedge clk);
        #1 tb_rst = 1'b0;
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        cyc(1'b1, 8'h44, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_reset_word", bus.rd_data, 32'h44332211);
        cyc(1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
